prbs_link_test_ctrl: RTL and testbench
======================================

Name: prbs_link_test_ctrl

Overview:
- Sequences a built-in link test over the PRBS31 generator → self-sync scrambler → self-sync descrambler chain.
- Enables the generator and controls scrambler bypass.
- Self-seeds a local PRBS31 reference (x^31+x^28+1) from the descrambled serial stream, detects lock, then counts bit errors over a programmed window.
- Reports lock, done and fail status to the link-control register block.

Parameters:
- LEN_W, 32, width of test_len and bit_cnt
- ERR_W, 16, width of err_cnt (saturating)
- LOCK_BITS, 64, consecutive error-free bits required to declare lock
- LOCK_TIMEOUT, 4096, max valid bits spent in SEED+LOCK before FAIL

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a test
- abort  in  1  one-cycle pulse, stops a test
- bypass_cfg  in  1  requested scrambler bypass during the test
- test_len  in  LEN_W  bits to check after lock; sampled on start
- rx_bit  in  1  descrambled serial data (descrambler serial_data_out)
- rx_valid  in  1  rx_bit qualifier; logic advances only when high
- gen_en  out  1  PRBS generator enable
- scr_bypass  out  1  scrambler/descrambler bypass
- busy  out  1  high in SEED, LOCK, COUNT
- locked  out  1  reference locked (LOCK→COUNT reached, held through DONE)
- done  out  1  window completed
- fail  out  1  lock timeout
- err_cnt  out  ERR_W  mismatches counted in COUNT
- bit_cnt  out  LEN_W  bits checked in COUNT

Behaviour:
- Reset: state=IDLE. All outputs 0. ref reg, counters, seed count and timeout count = 0.
- States: IDLE, SEED, LOCK, COUNT, DONE, FAIL. All outputs registered, updated on the cycle after the causing event.
- start in IDLE/DONE/FAIL:
  - Next state SEED; gen_en=1, scr_bypass=bypass_cfg (held until exit).
  - Clear err_cnt, bit_cnt, locked, done, fail, timeout count.
  - Latch test_len.
  - start in SEED/LOCK/COUNT is ignored.
- abort in any non-IDLE state: next IDLE; gen_en=0, scr_bypass=0, busy=0; err_cnt, bit_cnt, locked hold; done=fail=0. abort beats start in the same cycle.
- Reference: 31-bit reg r, r[0] newest. Predicted bit p = r[30]^r[27]. Mismatch m = rx_bit ^ p.
- SEED: each valid bit does r <= {r[29:0], rx_bit}, seed count +1. After the 31st valid bit, go to LOCK with match count 0.
- LOCK and COUNT: r is free-running, r <= {r[29:0], p}, so errors are not multiplied.
  - LOCK, m=0: match count +1. On reaching LOCK_BITS, go to COUNT and set locked=1.
  - LOCK, m=1: return to SEED, seed count 0. Timeout count keeps running.
- Timeout:
  - Timeout count increments on every valid bit in SEED and LOCK.
  - When it reaches LOCK_TIMEOUT before COUNT is entered: go to FAIL, fail=1, gen_en=0.
  - If lock completes on the same bit as the timeout, lock wins.
- COUNT: each valid bit increments bit_cnt. m=1 increments err_cnt, which saturates at all-ones and does not wrap.
  - When bit_cnt reaches the latched test_len: go to DONE, done=1, gen_en=0, scr_bypass=0, locked stays 1.
  - test_len=0: on lock, go straight to DONE with err_cnt=bit_cnt=0; no COUNT bits are checked.
- rx_valid=0: state, r and all counters hold.
- DONE/FAIL: hold status until start, abort or rst. rst mid-test behaves as power-on reset.

Optional Feature:
- PRBS_CHK_ERR_INJ_EN defined:
  - Adds input err_inj (1 bit).
  - When err_inj=1 together with rx_valid=1 in COUNT, the checker sees ~rx_bit for that bit, forcing exactly one counted error.
  - err_inj has no effect in other states.
- Undefined: no err_inj port; rx_bit is used unmodified.

Test Plan:
- Clean chain, bypass_cfg=0, test_len=1000, start after rst → locked rises after ≤31+58+LOCK_BITS+reseed valid bits; done=1; err_cnt=0; bit_cnt=1000; gen_en=0 the cycle after done.
- Clean chain, bypass_cfg=1, test_len=500 → scr_bypass=1 throughout busy; done with err_cnt=0, bit_cnt=500.
- Post-lock, flip rx_bit on 3 isolated bits, test_len=200 → err_cnt=3 exactly (free-running reference, no multiplication); done=1.
- rx_bit tied to 0, LOCK_TIMEOUT=4096 → fail=1 after 4096 valid bits; locked=0; gen_en=0.
- abort mid-COUNT at bit_cnt=123 → next cycle IDLE, busy=0, gen_en=0, bit_cnt=123 held. start and abort in the same cycle → stays IDLE.
- ERR_W=4, all-errors stream after lock (invert rx_bit), test_len=40 → err_cnt saturates at 15. With PRBS_CHK_ERR_INJ_EN, 2 err_inj pulses on a clean stream → err_cnt=2.

Source files
------------

// File: rtl/prbs_link_test_ctrl_if.sv
// rtl/prbs_link_test_ctrl_if.sv - control, serial-stream and status bundle for the PRBS link test controller
// PRBS_CHK_ERR_INJ_EN adds the err_inj strobe to the stream side.
interface prbs_link_test_ctrl_if #(
    parameter int LEN_W = 32,
    parameter int ERR_W = 16
);
    logic             start;
    logic             abort;
    logic             bypass_cfg;
    logic [LEN_W-1:0] test_len;
    logic             rx_bit;
    logic             rx_valid;
`ifdef PRBS_CHK_ERR_INJ_EN
    logic             err_inj;
`endif
    logic             gen_en;
    logic             scr_bypass;
    logic             busy;
    logic             locked;
    logic             done;
    logic             fail;
    logic [ERR_W-1:0] err_cnt;
    logic [LEN_W-1:0] bit_cnt;

    modport master (
        output start, abort, bypass_cfg, test_len, rx_bit, rx_valid,
`ifdef PRBS_CHK_ERR_INJ_EN
        output err_inj,
`endif
        input  gen_en, scr_bypass, busy, locked, done, fail, err_cnt, bit_cnt
    );

    modport slave (
        input  start, abort, bypass_cfg, test_len, rx_bit, rx_valid,
`ifdef PRBS_CHK_ERR_INJ_EN
        input  err_inj,
`endif
        output gen_en, scr_bypass, busy, locked, done, fail, err_cnt, bit_cnt
    );
endinterface

// File: rtl/prbs_link_test_ctrl.sv
// rtl/prbs_link_test_ctrl.sv - PRBS31 link test sequencer: self-seeding reference, lock detect, windowed bit-error count
// PRBS_CHK_ERR_INJ_EN enables single-bit error injection on the checked stream while counting.
module prbs_link_test_ctrl #(
    parameter int LEN_W        = 32,
    parameter int ERR_W        = 16,
    parameter int LOCK_BITS    = 64,
    parameter int LOCK_TIMEOUT = 4096
) (
    input logic                  clk,
    input logic                  rst,
    prbs_link_test_ctrl_if.slave lk
);
    localparam int MW = $clog2(LOCK_BITS + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_LOCK,
        S_COUNT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           state;
    logic [30:0]      ref_q;
    logic [4:0]       seed_cnt;
    logic [MW-1:0]    match_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_q;
    logic [ERR_W-1:0] err_q;
    logic             gen_q;
    logic             byp_q;
    logic             busy_q;
    logic             locked_q;
    logic             done_q;
    logic             fail_q;

    logic             pred;
    logic             chk_bit;
    logic             mis;
    logic             lock_hit;
    logic             tmo_hit;
    logic [30:0]      seed_word;
    logic [LEN_W-1:0] bit_nxt;

    // x^31 + x^28 + 1 with ref_q[0] the newest bit
    assign pred = ref_q[30] ^ ref_q[27];

`ifdef PRBS_CHK_ERR_INJ_EN
    assign chk_bit = lk.rx_bit ^ (lk.err_inj && (state == S_COUNT));
`else
    assign chk_bit = lk.rx_bit;
`endif

    assign mis       = chk_bit ^ pred;
    assign seed_word = {ref_q[29:0], lk.rx_bit};
    assign lock_hit  = !mis && (match_cnt == MW'(LOCK_BITS - 1));
    assign tmo_hit   = (tmo_cnt == TW'(LOCK_TIMEOUT - 1));
    assign bit_nxt   = bit_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ref_q     <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            tmo_cnt   <= '0;
            len_q     <= '0;
            bit_q     <= '0;
            err_q     <= '0;
            gen_q     <= 1'b0;
            byp_q     <= 1'b0;
            busy_q    <= 1'b0;
            locked_q  <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else if (lk.abort) begin
            if (state != S_IDLE) begin
                state  <= S_IDLE;
                gen_q  <= 1'b0;
                byp_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
                fail_q <= 1'b0;
            end
        end else if (lk.start && (state == S_IDLE || state == S_DONE || state == S_FAIL)) begin
            state     <= S_SEED;
            gen_q     <= 1'b1;
            byp_q     <= lk.bypass_cfg;
            busy_q    <= 1'b1;
            err_q     <= '0;
            bit_q     <= '0;
            locked_q  <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            tmo_cnt   <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            len_q     <= lk.test_len;
        end else if (lk.rx_valid) begin
            case (state)
                S_SEED: begin
                    ref_q   <= seed_word;
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (seed_cnt == 5'd30) begin
                        seed_cnt  <= '0;
                        match_cnt <= '0;
                        // an all-zero seed is the LFSR lock-up state and can never validate
                        if (seed_word != '0) begin
                            state <= S_LOCK;
                        end
                    end else begin
                        seed_cnt <= seed_cnt + 1'b1;
                    end
                    if (tmo_hit) begin
                        state  <= S_FAIL;
                        fail_q <= 1'b1;
                        gen_q  <= 1'b0;
                        byp_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                S_LOCK: begin
                    ref_q   <= {ref_q[29:0], pred};
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (mis) begin
                        state    <= S_SEED;
                        seed_cnt <= '0;
                    end else if (lock_hit) begin
                        locked_q <= 1'b1;
                        if (len_q == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            gen_q  <= 1'b0;
                            byp_q  <= 1'b0;
                            busy_q <= 1'b0;
                        end else begin
                            state <= S_COUNT;
                        end
                    end else begin
                        match_cnt <= match_cnt + 1'b1;
                    end
                    if (tmo_hit && !lock_hit) begin
                        state  <= S_FAIL;
                        fail_q <= 1'b1;
                        gen_q  <= 1'b0;
                        byp_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                S_COUNT: begin
                    // free-running reference keeps a single line error from echoing through the taps
                    ref_q <= {ref_q[29:0], pred};
                    bit_q <= bit_nxt;
                    if (mis && (err_q != '1)) begin
                        err_q <= err_q + 1'b1;
                    end
                    if (bit_nxt == len_q) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        gen_q  <= 1'b0;
                        byp_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign lk.gen_en     = gen_q;
    assign lk.scr_bypass = byp_q;
    assign lk.busy       = busy_q;
    assign lk.locked     = locked_q;
    assign lk.done       = done_q;
    assign lk.fail       = fail_q;
    assign lk.err_cnt    = err_q;
    assign lk.bit_cnt    = bit_q;
endmodule

// File: tb/tb_prbs_link_test_ctrl.sv
// tb/tb_prbs_link_test_ctrl.sv - self-checking bench for prbs_link_test_ctrl (default and 4-bit error counter instances)
module tb_prbs_link_test_ctrl;
    localparam int LEN_W = 32, ERR_W = 16, SW = 4, LOCK_BITS = 64, LOCK_TIMEOUT = 4096;
    localparam int M_IDLE = 0, M_SEED = 1, M_LOCK = 2, M_COUNT = 3, M_DONE = 4, M_FAIL = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prbs_link_test_ctrl_if #(.LEN_W(LEN_W), .ERR_W(ERR_W)) lk ();
    prbs_link_test_ctrl_if #(.LEN_W(LEN_W), .ERR_W(SW))    ls ();

    assign ls.start      = lk.start;
    assign ls.abort      = lk.abort;
    assign ls.bypass_cfg = lk.bypass_cfg;
    assign ls.test_len   = lk.test_len;
    assign ls.rx_bit     = lk.rx_bit;
    assign ls.rx_valid   = lk.rx_valid;
`ifdef PRBS_CHK_ERR_INJ_EN
    assign ls.err_inj    = lk.err_inj;
`endif

    prbs_link_test_ctrl #(.LEN_W(LEN_W), .ERR_W(ERR_W), .LOCK_BITS(LOCK_BITS), .LOCK_TIMEOUT(LOCK_TIMEOUT))
        dut (.clk(clk), .rst(rst), .lk(lk));
    prbs_link_test_ctrl #(.LEN_W(LEN_W), .ERR_W(SW), .LOCK_BITS(LOCK_BITS), .LOCK_TIMEOUT(LOCK_TIMEOUT))
        dut_s (.clk(clk), .rst(rst), .lk(ls));

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // behavioural model: reference kept as an oldest-first list of recent bits
    int     m_state;
    bit     m_gen, m_byp, m_locked, m_done, m_fail;
    longint m_err, m_bits, m_len;
    int     m_seedn, m_match, m_tmo;
    bit     hist[$];

    function automatic bit hist_nonzero();
        foreach (hist[i]) if (hist[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_gen = 0; m_byp = 0; m_locked = 0; m_done = 0; m_fail = 0;
        m_err = 0; m_bits = 0; m_len = 0; m_seedn = 0; m_match = 0; m_tmo = 0;
        hist.delete();
    endtask

    task automatic finish_window();
        m_state = M_DONE; m_done = 1; m_gen = 0; m_byp = 0;
    endtask

    task automatic model_step();
        bit inj, p, m, b;
        int prev;
        inj = 1'b0;
`ifdef PRBS_CHK_ERR_INJ_EN
        inj = lk.err_inj;
`endif
        if (lk.abort) begin
            if (m_state != M_IDLE) begin
                m_state = M_IDLE; m_gen = 0; m_byp = 0; m_done = 0; m_fail = 0;
            end
        end else if (lk.start && (m_state == M_IDLE || m_state == M_DONE || m_state == M_FAIL)) begin
            m_state = M_SEED; m_gen = 1; m_byp = lk.bypass_cfg;
            m_err = 0; m_bits = 0; m_locked = 0; m_done = 0; m_fail = 0;
            m_tmo = 0; m_seedn = 0; m_match = 0; m_len = longint'(lk.test_len);
            hist.delete();
        end else if (lk.rx_valid) begin
            prev = m_state;
            if (m_state == M_SEED) begin
                hist.push_back(lk.rx_bit);
                if (hist.size() > 31) void'(hist.pop_front());
                m_seedn++; m_tmo++;
                if (m_seedn == 31) begin
                    m_seedn = 0; m_match = 0;
                    if (hist_nonzero()) m_state = M_LOCK;
                end
            end else if (m_state == M_LOCK || m_state == M_COUNT) begin
                p = hist[0] ^ hist[3];
                hist.push_back(p);
                void'(hist.pop_front());
                b = lk.rx_bit ^ (inj && m_state == M_COUNT);
                m = b ^ p;
                if (m_state == M_LOCK) begin
                    m_tmo++;
                    if (!m) begin
                        m_match++;
                        if (m_match == LOCK_BITS) begin
                            m_locked = 1;
                            if (m_len == 0) finish_window();
                            else m_state = M_COUNT;
                        end
                    end else begin
                        m_state = M_SEED; m_seedn = 0;
                    end
                end else begin
                    m_bits++;
                    if (m) m_err++;
                    if (m_bits == m_len) finish_window();
                end
            end
            if ((prev == M_SEED || prev == M_LOCK) && m_state != M_COUNT && m_state != M_DONE
                && m_tmo == LOCK_TIMEOUT) begin
                m_state = M_FAIL; m_fail = 1; m_gen = 0; m_byp = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("gen_en",       lk.gen_en,     m_gen);
            chk("scr_bypass",   lk.scr_bypass, m_byp);
            chk("busy",         lk.busy,       (m_state == M_SEED || m_state == M_LOCK || m_state == M_COUNT));
            chk("locked",       lk.locked,     m_locked);
            chk("done",         lk.done,       m_done);
            chk("fail",         lk.fail,       m_fail);
            chk("err_cnt",      lk.err_cnt,    sat(m_err, ERR_W));
            chk("bit_cnt",      lk.bit_cnt,    m_bits);
            chk("s.busy",       ls.busy,       (m_state == M_SEED || m_state == M_LOCK || m_state == M_COUNT));
            chk("s.done",       ls.done,       m_done);
            chk("s.err_cnt",    ls.err_cnt,    sat(m_err, SW));
            chk("s.bit_cnt",    ls.bit_cnt,    m_bits);
        end
    end

    // stimulus: continuous PRBS31 source with optional corruptions
    logic [30:0] g = 31'h2A5C_3E71;
    int     vphase = 0;
    int     nv = 0;
    bit     pr_zero = 0, pr_inv = 0;
    longint flip_at[$];
    longint inj_at[$];
    longint abort_at = -1;
    longint restart_at = -1;

    task automatic tick(input bit st, input bit ab);
        bit b;
        @(posedge clk);
        #1;
        if (lk.rx_valid && !lk.start) nv++;
        lk.start = st;
        lk.abort = ab || (m_state == M_COUNT && m_bits == abort_at);
`ifdef PRBS_CHK_ERR_INJ_EN
        lk.err_inj = 1'b0;
`endif
        lk.rx_valid = (vphase % 7) != 3;
        vphase++;
        if (lk.rx_valid) begin
            b = g[30] ^ g[27];
            g = {g[29:0], b};
            if (pr_zero) b = 1'b0;
            if (m_state == M_COUNT) begin
                if (pr_inv) b = ~b;
                foreach (flip_at[i]) if (m_bits == flip_at[i]) b = ~b;
`ifdef PRBS_CHK_ERR_INJ_EN
                foreach (inj_at[i]) if (m_bits == inj_at[i]) lk.err_inj = 1'b1;
`endif
            end
            lk.rx_bit = b;
        end else begin
            lk.rx_bit = ~lk.rx_bit;
        end
    endtask

    int lock_nv, end_nv;
    bit byp_at_lock;

    task automatic run(input bit byp, input longint len, input int budget);
        bit timed_out;
        lk.bypass_cfg = byp;
        lk.test_len   = LEN_W'(len);
        tick(1, 0);
        nv = 0; lock_nv = -1; byp_at_lock = 0; timed_out = 1;
        for (int i = 0; i < budget; i++) begin
            tick(restart_at >= 0 && m_state == M_COUNT && m_bits == restart_at, 0);
            if (lk.locked && lock_nv < 0) begin
                lock_nv = nv;
                byp_at_lock = lk.scr_bypass;
            end
            if (!lk.busy) begin
                timed_out = 0;
                break;
            end
        end
        end_nv = nv;
        chk("run_timeout", timed_out, 0);
    endtask

    initial begin
        rst = 1'b1;
        lk.start = 0; lk.abort = 0; lk.bypass_cfg = 0; lk.test_len = '0;
        lk.rx_bit = 0; lk.rx_valid = 0;
`ifdef PRBS_CHK_ERR_INJ_EN
        lk.err_inj = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gen_en", lk.gen_en, 0);
        chk("rst_busy",   lk.busy,   0);
        chk("rst_status", {lk.locked, lk.done, lk.fail, lk.scr_bypass}, 0);
        chk("rst_counts", {lk.err_cnt, lk.bit_cnt}, 0);
        cmp_en = 1;
        rst = 1'b0;

        // clean stream, with an ignored start mid-window
        restart_at = 300;
        run(0, 1000, 3000);
        restart_at = -1;
        chk("A_lock_bits", lock_nv, 95);
        chk("A_done",      lk.done, 1);
        chk("A_err",       lk.err_cnt, 0);
        chk("A_bits",      lk.bit_cnt, 1000);
        chk("A_gen_off",   lk.gen_en, 0);

        // bypass requested
        run(1, 500, 2000);
        chk("B_byp_busy",  byp_at_lock, 1);
        chk("B_done",      lk.done, 1);
        chk("B_err",       lk.err_cnt, 0);
        chk("B_bits",      lk.bit_cnt, 500);
        chk("B_byp_off",   lk.scr_bypass, 0);

        // three isolated line errors
        flip_at = '{10, 60, 120};
        run(0, 200, 1000);
        flip_at.delete();
        chk("C_err",  lk.err_cnt, 3);
        chk("C_done", lk.done, 1);

        // stuck-at-zero line never locks
        pr_zero = 1;
        run(0, 100, 6000);
        pr_zero = 0;
        chk("D_fail",     lk.fail, 1);
        chk("D_fail_at",  end_nv, 4096);
        chk("D_locked",   lk.locked, 0);
        chk("D_gen_off",  lk.gen_en, 0);

        // zero-length window
        run(0, 0, 500);
        chk("Z_done",   lk.done, 1);
        chk("Z_locked", lk.locked, 1);
        chk("Z_end_at", end_nv, 95);
        chk("Z_bits",   lk.bit_cnt, 0);

        // abort mid-window, then start+abort together
        abort_at = 123;
        run(0, 1000, 3000);
        abort_at = -1;
        chk("E_busy",   lk.busy, 0);
        chk("E_gen",    lk.gen_en, 0);
        chk("E_bits",   lk.bit_cnt, 123);
        chk("E_locked", lk.locked, 1);
        tick(1, 1);
        tick(0, 0);
        chk("E_sa_busy", lk.busy, 0);
        chk("E_sa_gen",  lk.gen_en, 0);
        chk("E_sa_bits", lk.bit_cnt, 123);

        // every window bit wrong
        pr_inv = 1;
        run(0, 40, 500);
        pr_inv = 0;
        chk("F_err_sat", ls.err_cnt, 15);
        chk("F_err",     lk.err_cnt, 40);
        chk("F_bits",    lk.bit_cnt, 40);

`ifdef PRBS_CHK_ERR_INJ_EN
        inj_at = '{7, 33};
        run(0, 100, 500);
        inj_at.delete();
        chk("G_inj_err", lk.err_cnt, 2);
        chk("G_done",    lk.done, 1);
`endif

        repeat (2) tick(0, 0);
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
